j1_code_loader: RTL and testbench

Boot sequencer for the J1 core. Holds the CPU in reset after power-up, accepts a framed code image over a byte stream (UART receiver side), and writes it word-by-word into the 16-bit code RAM. It releases the CPU on a valid image or on timeout, and re-enters loading on request. Sits between the UART RX, the code RAM write port and the core's `resetq` input.

---
 rtl/j1_pkg.sv | 34 +++
 rtl/j1_code_loader.sv | 217 +++++++++++++++++++++
 tb/tb_j1_code_loader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/j1_pkg.sv
// Shared J1 definitions: loader state encoding, frame constants and byte helpers.
// Also imported by the core and the code RAM for the common address width.
package j1_pkg;

  localparam int         J1_CODE_AW = 13;
  localparam logic [7:0] J1_MAGIC   = 8'hA5;

  typedef enum logic [2:0] {
    ST_WAIT_MAGIC = 3'd0,
    ST_LEN_LO     = 3'd1,
    ST_LEN_HI     = 3'd2,
    ST_DATA_LO    = 3'd3,
    ST_DATA_HI    = 3'd4,
    ST_CSUM       = 3'd5,
    ST_RUN        = 3'd6,
    ST_ERROR      = 3'd7
  } j1_loader_state_t;

  // Multi-byte frame fields (length and data words) travel low byte first.
  function automatic logic [15:0] j1_join(input logic [7:0] first_byte,
                                          input logic [7:0] second_byte);
    return {second_byte, first_byte};
  endfunction

  function automatic logic [7:0] j1_csum_upd(input logic [7:0] csum,
                                             input logic [7:0] data);
    return csum ^ data;
  endfunction

  function automatic logic j1_len_exceeds(input logic [15:0] len, input int aw);
    return {1'b0, len} > (17'd1 << aw);
  endfunction

endpackage

// File: rtl/j1_code_loader.sv
// Boot sequencer: holds the J1 in reset, loads a framed image from the UART
// byte stream into code RAM, then releases the core on success or timeout.
module j1_code_loader
  import j1_pkg::*;
#(
  parameter int         CODE_AW = J1_CODE_AW,
  parameter int         TIMEOUT = 1000000,
  parameter logic [7:0] MAGIC   = J1_MAGIC
) (
  input  logic               clk,
  input  logic               resetq,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               load_req,
  output logic               code_we,
  output logic [CODE_AW-1:0] code_waddr,
  output logic [15:0]        code_wdata,
  output logic               cpu_resetq,
  output logic               load_ok,
  output logic               load_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  j1_loader_state_t   r_state;
  j1_loader_state_t   w_next;
  logic [TMO_W-1:0]   r_tmo;
  logic [15:0]        r_cnt;
  logic [7:0]         r_csum;
  logic [7:0]         r_lo;
  logic               r_we;
  logic [CODE_AW-1:0] r_waddr;
  logic [15:0]        r_wdata;
  logic               r_cpu;
  logic               r_ok;
  logic               r_err;

  logic               w_rx_ready;
  logic               w_take;
  logic               w_magic;
  logic [15:0]        w_len;
  logic               w_len_big;

  assign w_rx_ready = (r_state != ST_RUN);
  // A byte coinciding with load_req is dropped, so it never counts as taken.
  assign w_take     = rx_valid && w_rx_ready && !load_req;
  assign w_magic    = w_take && (rx_data == MAGIC) &&
                      ((r_state == ST_WAIT_MAGIC) || (r_state == ST_ERROR));
  assign w_len      = j1_join(r_cnt[7:0], rx_data);
  assign w_len_big  = j1_len_exceeds(w_len, CODE_AW);

  // State register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state <= ST_WAIT_MAGIC;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a MAGIC byte beats the timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    if (load_req) begin
      w_next = ST_WAIT_MAGIC;
    end else begin
      case (r_state)
        ST_WAIT_MAGIC: begin
          if (w_magic) begin
            w_next = ST_LEN_LO;
          end else if (r_tmo == TMO_LAST) begin
            w_next = ST_RUN;
          end else begin
            w_next = ST_WAIT_MAGIC;
          end
        end
        ST_LEN_LO: begin
          if (w_take) begin
            w_next = ST_LEN_HI;
          end else begin
            w_next = ST_LEN_LO;
          end
        end
        ST_LEN_HI: begin
          if (!w_take) begin
            w_next = ST_LEN_HI;
          end else if (w_len == 16'd0) begin
            w_next = ST_CSUM;
          end else if (w_len_big) begin
            w_next = ST_ERROR;
          end else begin
            w_next = ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (w_take) begin
            w_next = ST_DATA_HI;
          end else begin
            w_next = ST_DATA_LO;
          end
        end
        ST_DATA_HI: begin
          if (!w_take) begin
            w_next = ST_DATA_HI;
          end else if (r_cnt == 16'd1) begin
            w_next = ST_CSUM;
          end else begin
            w_next = ST_DATA_LO;
          end
        end
        ST_CSUM: begin
          if (!w_take) begin
            w_next = ST_CSUM;
          end else if (rx_data == r_csum) begin
            w_next = ST_RUN;
          end else begin
            w_next = ST_ERROR;
          end
        end
        ST_RUN: begin
          w_next = ST_RUN;
        end
        ST_ERROR: begin
          if (w_magic) begin
            w_next = ST_LEN_LO;
          end else begin
            w_next = ST_ERROR;
          end
        end
        default: begin
          w_next = ST_WAIT_MAGIC;
        end
      endcase
    end
  end

  // Frame datapath: counters, checksum, write port and status flags.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_tmo   <= '0;
      r_cnt   <= 16'd0;
      r_csum  <= 8'd0;
      r_lo    <= 8'd0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 16'd0;
      r_cpu   <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we  <= w_take && (r_state == ST_DATA_HI);
      r_cpu <= (r_state == ST_RUN) && !load_req;

      if (load_req) begin
        r_tmo <= '0;
      end else if (r_state == ST_WAIT_MAGIC) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end

      if (w_magic) begin
        r_waddr <= '0;
        r_csum  <= 8'd0;
        r_ok    <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        // Address advances only after its strobe has been presented.
        if (r_we) begin
          r_waddr <= r_waddr + CODE_AW'(1);
        end
        if (w_take) begin
          case (r_state)
            ST_LEN_LO: begin
              r_cnt  <= {8'd0, rx_data};
              r_csum <= j1_csum_upd(r_csum, rx_data);
            end
            ST_LEN_HI: begin
              r_cnt  <= w_len;
              r_csum <= j1_csum_upd(r_csum, rx_data);
              if (w_len_big) begin
                r_err <= 1'b1;
              end
            end
            ST_DATA_LO: begin
              r_lo   <= rx_data;
              r_csum <= j1_csum_upd(r_csum, rx_data);
            end
            ST_DATA_HI: begin
              r_wdata <= j1_join(r_lo, rx_data);
              r_cnt   <= r_cnt - 16'd1;
              r_csum  <= j1_csum_upd(r_csum, rx_data);
            end
            ST_CSUM: begin
              if (rx_data == r_csum) begin
                r_ok <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign rx_ready   = w_rx_ready;
  assign code_we    = r_we;
  assign code_waddr = r_waddr;
  assign code_wdata = r_wdata;
  assign cpu_resetq = r_cpu;
  assign load_ok    = r_ok;
  assign load_err   = r_err;

endmodule

// File: tb/tb_j1_code_loader.sv
// Directed bench for j1_code_loader with TIMEOUT=16 and an 8192-word image space.
module tb_j1_code_loader;

  logic        clk = 1'b0;
  logic        resetq;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        load_req;
  logic        code_we;
  logic [12:0] code_waddr;
  logic [15:0] code_wdata;
  logic        cpu_resetq;
  logic        load_ok;
  logic        load_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          base;
  logic [12:0] we_addr[$];
  logic [15:0] we_data[$];

  j1_code_loader #(.CODE_AW(13), .TIMEOUT(16), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .resetq     (resetq),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .load_req   (load_req),
    .code_we    (code_we),
    .code_waddr (code_waddr),
    .code_wdata (code_wdata),
    .cpu_resetq (cpu_resetq),
    .load_ok    (load_ok),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Write-port monitor: log every strobe seen mid-cycle.
  always @(negedge clk) begin
    if (resetq && code_we) begin
      we_addr.push_back(code_waddr);
      we_data.push_back(code_wdata);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetq   = 1'b0;
    rx_valid = 1'b0;
    load_req = 1'b0;
    @(negedge clk);
    resetq = 1'b1;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_good_frame();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h0A);
    idle();
  endtask

  initial begin
    resetq   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    load_req = 1'b0;
    wait_neg(2);
    check("rst_we", code_we, 0);
    check("rst_waddr", code_waddr, 0);
    check("rst_wdata", code_wdata, 0);
    check("rst_cpu", cpu_resetq, 0);
    check("rst_ok", load_ok, 0);
    check("rst_err", load_err, 0);
    check("rst_ready", rx_ready, 1);

    // Timeout with no traffic.
    resetq = 1'b1;
    wait_neg(15);
    check("t1_ready_pre", rx_ready, 1);
    wait_neg(1);
    check("t1_ready_run", rx_ready, 0);
    check("t1_cpu_pre", cpu_resetq, 0);
    wait_neg(1);
    check("t1_cpu_run", cpu_resetq, 1);
    check("t1_no_writes", we_addr.size(), 0);

    // Valid two-word frame.
    do_reset();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    send(8'h78);
    check("t2_we_lat", code_we, 1);
    check("t2_addr0", code_waddr, 0);
    check("t2_data0", code_wdata, 16'h1234);
    send(8'h56);
    check("t2_we_single", code_we, 0);
    check("t2_addr_inc", code_waddr, 1);
    send(8'h0A);
    check("t2_we2", code_we, 1);
    check("t2_addr1", code_waddr, 1);
    check("t2_data1", code_wdata, 16'h5678);
    idle();
    check("t2_ok", load_ok, 1);
    check("t2_err", load_err, 0);
    check("t2_ready_run", rx_ready, 0);
    check("t2_cpu_pre", cpu_resetq, 0);
    wait_neg(1);
    check("t2_cpu", cpu_resetq, 1);
    #1;
    check("t2_nwrites", we_addr.size(), 2);

    // load_req in RUN: immediate hold, timeout restarts.
    pulse_req();
    check("t6_cpu_drop", cpu_resetq, 0);
    check("t6_ready", rx_ready, 1);
    wait_neg(15);
    check("t6_tmo_pre", rx_ready, 1);
    wait_neg(1);
    check("t6_tmo_run", rx_ready, 0);
    wait_neg(1);
    check("t6_tmo_cpu", cpu_resetq, 1);

    // Bad checksum, then recovery.
    pulse_req();
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    send(8'h0B);
    idle();
    check("t3_err", load_err, 1);
    check("t3_ok", load_ok, 0);
    check("t3_ready", rx_ready, 1);
    wait_neg(20);
    check("t3_cpu_held", cpu_resetq, 0);
    send_good_frame();
    check("t3_ok2", load_ok, 1);
    check("t3_err2", load_err, 0);
    wait_neg(1);
    check("t3_cpu2", cpu_resetq, 1);

    // Zero length frame.
    pulse_req();
    #1;
    base = we_addr.size();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    idle();
    check("t4_zero_ok", load_ok, 1);
    wait_neg(1);
    check("t4_zero_cpu", cpu_resetq, 1);
    #1;
    check("t4_zero_nowr", we_addr.size(), base);

    // Oversize length.
    pulse_req();
    send(8'hA5); send(8'h01); send(8'h20);
    idle();
    check("t4_big_err", load_err, 1);
    check("t4_big_ok", load_ok, 0);
    check("t4_big_ready", rx_ready, 1);
    wait_neg(20);
    check("t4_big_cpu", cpu_resetq, 0);
    #1;
    check("t4_big_nowr", we_addr.size(), base);

    // load_req together with the high data byte.
    pulse_req();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h34);
    @(negedge clk);
    rx_data  = 8'h12;
    rx_valid = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    check("t6_drop_we", code_we, 0);
    #1;
    check("t6_drop_nowr", we_addr.size(), base);
    send(8'hA5); send(8'h01); send(8'h00); send(8'hCD); send(8'hAB); send(8'h67);
    idle();
    check("t6_reload_ok", load_ok, 1);
    #1;
    check("t6_reload_n", we_addr.size(), base + 1);
    check("t6_reload_a", we_addr[base], 0);
    check("t6_reload_d", we_data[base], 16'hABCD);

    // Asynchronous reset mid-frame.
    pulse_req();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h11); send(8'h22);
    send(8'h33);
    check("t6_mid_we", code_we, 1);
    check("t6_mid_data", code_wdata, 16'h2211);
    resetq   = 1'b0;
    rx_valid = 1'b0;
    #1;
    check("t6_ar_we", code_we, 0);
    check("t6_ar_waddr", code_waddr, 0);
    check("t6_ar_wdata", code_wdata, 0);
    check("t6_ar_cpu", cpu_resetq, 0);
    check("t6_ar_ready", rx_ready, 1);
    @(negedge clk);
    resetq = 1'b1;
    wait_neg(16);
    check("t6_ar_tmo", rx_ready, 0);
    check("t6_ar_cpu_held", cpu_resetq, 0);

    // Stray byte does not restart the timer.
    do_reset();
    wait_neg(1);
    send(8'h11);
    idle();
    wait_neg(12);
    check("t5_ready_pre", rx_ready, 1);
    wait_neg(1);
    check("t5_tmo", rx_ready, 0);

    // MAGIC in the timeout cycle wins.
    do_reset();
    wait_neg(1);
    send(8'h11);
    idle();
    wait_neg(11);
    send(8'hA5);
    idle();
    check("t5_magic_ready", rx_ready, 1);
    check("t5_magic_cpu", cpu_resetq, 0);
    wait_neg(2);
    check("t5_held_ready", rx_ready, 1);
    check("t5_held_cpu", cpu_resetq, 0);
    send(8'h00); send(8'h00); send(8'h00);
    idle();
    check("t5_ok", load_ok, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
